// File: rtl/i2c_arb_pkg.sv
// Shared types, default constants and the round-robin pick function for the I2C requester arbiter.
package i2c_arb_pkg;

    localparam int unsigned N_REQ_DEF       = 4;
    localparam int unsigned ADDR_W_DEF      = 7;
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned MAX_RETRY_DEF   = 2;
    localparam int unsigned BACKOFF_CYC_DEF = 16;
    localparam int unsigned TIMEOUT_CYC_DEF = 65535;

    // Upper bound on requesters; the pick function is written for this width.
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned IDX_MAX_W = 3;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_DONE,
        ARB_BACKOFF,
        ARB_RESP
    } arb_state_t;

    // First set bit of req searching circularly from ptr over n entries.
    function automatic logic [IDX_MAX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [IDX_MAX_W-1:0] ptr,
        input int unsigned          n
    );
        logic [IDX_MAX_W-1:0] idx;
        logic [IDX_MAX_W:0]   pos;
        logic                 found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = {1'b0, ptr} + (IDX_MAX_W + 1)'(k);
            if (pos >= (IDX_MAX_W + 1)'(n)) begin
                pos = pos - (IDX_MAX_W + 1)'(n);
            end
            if (!found && (k < n) && req[pos[IDX_MAX_W-1:0]]) begin
                idx   = pos[IDX_MAX_W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin priority picker: first requester at or after ptr, wrapping.
module i2c_rr_picker
    import i2c_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = N_REQ_DEF,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx_c,
    output logic             pick_valid_c
);

    logic [IDX_MAX_W-1:0] pick_full;

    assign pick_full    = rr_pick(MAX_REQ'(req), IDX_MAX_W'(ptr), N_REQ);
    assign pick_idx_c   = IDX_W'(pick_full);
    assign pick_valid_c = |req;

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_fsm write master between N_REQ requesters, with NACK retry.
// Optional watchdog on WAIT_DONE and sticky timeout_flag port when I2C_ARB_TIMEOUT_EN is defined.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter  int unsigned N_REQ       = N_REQ_DEF,
    parameter  int unsigned ADDR_W      = ADDR_W_DEF,
    parameter  int unsigned DATA_W      = DATA_W_DEF,
    parameter  int unsigned MAX_RETRY   = MAX_RETRY_DEF,
    parameter  int unsigned BACKOFF_CYC = BACKOFF_CYC_DEF,
    parameter  int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int unsigned IDX_W       = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic                    rsp_err,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic                    arb_busy,
    output logic                    m_en,
    output logic                    m_start,
    output logic [ADDR_W-1:0]       m_addr7,
    output logic [DATA_W-1:0]       m_tx_data,
    output logic                    m_tx_data_valid,
`ifdef I2C_ARB_TIMEOUT_EN
    output logic                    timeout_flag,
`endif
    input  logic                    m_busy,
    input  logic                    m_done,
    input  logic                    m_ack_error
);

    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned BO_W    = (BACKOFF_CYC < 2) ? 1 : $clog2(BACKOFF_CYC);

    if ((N_REQ < 2) || (N_REQ > MAX_REQ) || (BACKOFF_CYC < 1) || (TIMEOUT_CYC < 1)
        || (ADDR_W < 1) || (DATA_W < 1)) begin : g_param_check
        $error("i2c_req_arbiter: parameter out of range");
    end

    arb_state_t          state, state_d;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
    logic [RETRY_W-1:0]  retry_cnt, retry_d;
    logic                err_seen, err_seen_d;
    logic [BO_W-1:0]     bo_cnt, bo_cnt_d;
    logic                done_err;

    logic [N_REQ-1:0]    rsp_valid_d;
    logic                rsp_err_d;
    logic [IDX_W-1:0]    gnt_idx_d;
    logic                arb_busy_d;
    logic                m_start_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_d;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wd_cnt, wd_cnt_d;
    logic                timeout_flag_d;
`endif

    logic [IDX_W-1:0]    pick_idx_c;
    logic                pick_valid_c;
    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic [DATA_W-1:0]   data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    i2c_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req          (req),
        .ptr          (rr_ptr),
        .pick_idx_c   (pick_idx_c),
        .pick_valid_c (pick_valid_c)
    );

    // Next-state and next-output logic; outputs are registered from these *_d values.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        retry_d     = retry_cnt;
        err_seen_d  = err_seen;
        bo_cnt_d    = bo_cnt;
        gnt_idx_d   = gnt_idx;
        addr_d      = m_addr7;
        data_d      = m_tx_data;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        done_err    = err_seen | m_ack_error;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_cnt_d       = wd_cnt;
        timeout_flag_d = timeout_flag;
`endif

        case (state)
            ARB_IDLE: begin
                if (enable && pick_valid_c && !m_busy) begin
                    state_d    = ARB_ISSUE;
                    gnt_idx_d  = pick_idx_c;
                    addr_d     = addr_arr[pick_idx_c];
                    data_d     = data_arr[pick_idx_c];
                    retry_d    = '0;
                    err_seen_d = 1'b0;
                end
            end
            ARB_ISSUE: begin
                err_seen_d = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
                wd_cnt_d   = '0;
`endif
                state_d    = ARB_WAIT_DONE;
            end
            ARB_WAIT_DONE: begin
                err_seen_d = done_err;
`ifdef I2C_ARB_TIMEOUT_EN
                wd_cnt_d   = wd_cnt + WD_W'(1);
`endif
                if (m_done) begin
                    if (done_err && (retry_cnt < RETRY_W'(MAX_RETRY))) begin
                        state_d  = ARB_BACKOFF;
                        retry_d  = retry_cnt + RETRY_W'(1);
                        bo_cnt_d = '0;
                    end else begin
                        state_d              = ARB_RESP;
                        rsp_valid_d[gnt_idx] = 1'b1;
                        rsp_err_d            = done_err;
                    end
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d              = ARB_RESP;
                    rsp_valid_d[gnt_idx] = 1'b1;
                    rsp_err_d            = 1'b1;
                    timeout_flag_d       = 1'b1;
                end
`endif
            end
            ARB_BACKOFF: begin
                // Retries proceed regardless of enable so a started transaction always finishes.
                if (bo_cnt == BO_W'(BACKOFF_CYC - 1)) begin
                    state_d = ARB_ISSUE;
                end else begin
                    bo_cnt_d = bo_cnt + BO_W'(1);
                end
            end
            ARB_RESP: begin
                rr_ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                state_d  = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        m_start_d  = (state_d == ARB_ISSUE);
        arb_busy_d = (state_d != ARB_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARB_IDLE;
            rr_ptr          <= '0;
            retry_cnt       <= '0;
            err_seen        <= 1'b0;
            bo_cnt          <= '0;
            rsp_valid       <= '0;
            rsp_err         <= 1'b0;
            gnt_idx         <= '0;
            arb_busy        <= 1'b0;
            m_en            <= 1'b0;
            m_start         <= 1'b0;
            m_addr7         <= '0;
            m_tx_data       <= '0;
            m_tx_data_valid <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt          <= '0;
            timeout_flag    <= 1'b0;
`endif
        end else begin
            state           <= state_d;
            rr_ptr          <= rr_ptr_d;
            retry_cnt       <= retry_d;
            err_seen        <= err_seen_d;
            bo_cnt          <= bo_cnt_d;
            rsp_valid       <= rsp_valid_d;
            rsp_err         <= rsp_err_d;
            gnt_idx         <= gnt_idx_d;
            arb_busy        <= arb_busy_d;
            m_en            <= enable;
            m_start         <= m_start_d;
            m_addr7         <= addr_d;
            m_tx_data       <= data_d;
            m_tx_data_valid <= m_start_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt          <= wd_cnt_d;
            timeout_flag    <= timeout_flag_d;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized self-checking bench for i2c_req_arbiter against a transaction-level reference model.
module tb_i2c_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
    localparam int unsigned MR = 2;
    localparam int unsigned BO = 16;
    localparam int unsigned TO = 100;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    rsp_valid;
    logic            rsp_err;
    logic [1:0]      gnt_idx;
    logic            arb_busy;
    logic            m_en;
    logic            m_start;
    logic [AW-1:0]   m_addr7;
    logic [DW-1:0]   m_tx_data;
    logic            m_tx_data_valid;
    logic            m_busy;
    logic            m_done;
    logic            m_ack_error;
`ifdef I2C_ARB_TIMEOUT_EN
    logic            timeout_flag;
`endif

    i2c_req_arbiter #(
        .N_REQ       (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_RETRY   (MR),
        .BACKOFF_CYC (BO),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .req             (req),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_err         (rsp_err),
        .gnt_idx         (gnt_idx),
        .arb_busy        (arb_busy),
        .m_en            (m_en),
        .m_start         (m_start),
        .m_addr7         (m_addr7),
        .m_tx_data       (m_tx_data),
        .m_tx_data_valid (m_tx_data_valid),
`ifdef I2C_ARB_TIMEOUT_EN
        .timeout_flag    (timeout_flag),
`endif
        .m_busy          (m_busy),
        .m_done          (m_done),
        .m_ack_error     (m_ack_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: round-robin pointer and each requester's posted payload.
    int            rr = 0;
    logic [AW-1:0] ma [N];
    logic [DW-1:0] md [N];
    bit            hold_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < int'(N); k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic post(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ma[i] = a;
        md[i] = d;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    task automatic post_random_new();
        for (int i = 0; i < int'(N); i++) begin
            if (!req[i] && ($urandom_range(0, 1) == 1)) post(i, AW'($urandom), DW'($urandom));
        end
        if (req == '0) post(int'($urandom_range(0, N - 1)), AW'($urandom), DW'($urandom));
    endtask

    // Acts as the i2c_fsm slave for one granted transaction and checks every attempt and the response.
    task automatic serve(input int exp, input int nacks, input bit keep, input bit drop_en);
        int att_exp;
        bit err_exp;
        int last_done;
        att_exp   = (nacks > int'(MR)) ? int'(MR) + 1 : nacks + 1;
        err_exp   = (nacks > int'(MR));
        last_done = 0;
        for (int a = 0; a < att_exp; a++) begin
            int waited = 0;
            bit nack_now = (a < nacks);
            int mode = int'($urandom_range(0, 2));
            int lat = int'($urandom_range(2, 5));
            do begin
                @(negedge clk);
                waited++;
            end while (!m_start && waited < 200);
            if (!m_start) begin
                check("start_seen", 32'(m_start), 32'(1));
                return;
            end
            check("gnt_idx", 32'(gnt_idx), 32'(exp));
            check("m_addr7", 32'(m_addr7), 32'(ma[exp]));
            check("m_tx_data", 32'(m_tx_data), 32'(md[exp]));
            check("m_tx_data_valid", 32'(m_tx_data_valid), 32'(1));
            check("arb_busy", 32'(arb_busy), 32'(1));
            if (a > 0) check("backoff_gap", 32'((cyc - last_done - 1) >= int'(BO)), 32'(1));
            m_busy = 1'b1;
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    check("start_pulse", 32'(m_start), 32'(0));
                    if (drop_en && a == 0) enable = 1'b0;
                end
                m_done      = (c == lat);
                m_ack_error = nack_now && (mode == 0 || (mode == 1 && c == lat) || (mode == 2 && c != lat));
            end
            last_done = cyc;
            @(negedge clk);
            m_done      = 1'b0;
            m_ack_error = 1'b0;
            m_busy      = hold_busy;
            if (a == att_exp - 1) begin
                check("rsp_valid", 32'(rsp_valid), 32'(1) << exp);
                check("rsp_err", 32'(rsp_err), 32'(err_exp));
                if (!keep) req[exp] = 1'b0;
            end else begin
                check("rsp_quiet", 32'(rsp_valid), 32'(0));
                check("rsp_err_quiet", 32'(rsp_err), 32'(0));
            end
        end
        rr = (exp + 1) % N;
    endtask

    task automatic expect_no_grant(input string tag, input int cycles);
        int starts = 0;
        int busy_seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (m_start) starts++;
            if (arb_busy) busy_seen++;
        end
        check(tag, 32'(starts), 32'(0));
        check({tag, "_busy"}, 32'(busy_seen), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        int exp;
        rst_n       = 1'b0;
        enable      = 1'b0;
        req         = '0;
        req_addr    = '0;
        req_data    = '0;
        m_busy      = 1'b0;
        m_done      = 1'b0;
        m_ack_error = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_err", 32'(rsp_err), 32'(0));
        check("rst_gnt_idx", 32'(gnt_idx), 32'(0));
        check("rst_arb_busy", 32'(arb_busy), 32'(0));
        check("rst_m_en", 32'(m_en), 32'(0));
        check("rst_m_start", 32'(m_start), 32'(0));
        check("rst_m_addr7", 32'(m_addr7), 32'(0));
        check("rst_m_tx_data", 32'(m_tx_data), 32'(0));
        check("rst_m_tx_valid", 32'(m_tx_data_valid), 32'(0));
`ifdef I2C_ARB_TIMEOUT_EN
        check("rst_timeout_flag", 32'(timeout_flag), 32'(0));
`endif

        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("m_en_follow", 32'(m_en), 32'(1));

        // Single request with ACK.
        post(1, 7'h50, 8'hA5);
        serve(model_pick(req, rr), 0, 1'b0, 1'b0);

        // Reset in the middle of a transaction: no response, pointer back to 0.
        post(0, AW'($urandom), DW'($urandom));
        post(1, AW'($urandom), DW'($urandom));
        post(2, AW'($urandom), DW'($urandom));
        post(3, AW'($urandom), DW'($urandom));
        exp = 0;
        for (int w = 0; w < 50 && !m_start; w++) @(negedge clk);
        check("abort_gnt", 32'(gnt_idx), 32'(model_pick(req, rr)));
        m_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        check("abort_arb_busy", 32'(arb_busy), 32'(0));
        check("abort_gnt_idx", 32'(gnt_idx), 32'(0));
        check("abort_m_addr7", 32'(m_addr7), 32'(0));
        m_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr    = 0;

        // All four requesting continuously: strict rotation.
        for (int k = 0; k < 5; k++) serve(order[k], 0, 1'b1, 1'b0);

        // NACK twice then ACK, then persistent NACK, then NACK on every attempt with error.
        serve(model_pick(req, rr), 2, 1'b0, 1'b0);
        serve(model_pick(req, rr), 3, 1'b0, 1'b0);
        serve(model_pick(req, rr), 5, 1'b0, 1'b0);

        // enable dropped while waiting for done: transaction completes, then no grants.
        if (req == '0) post_random_new();
        serve(model_pick(req, rr), 1, 1'b0, 1'b1);
        check("m_en_low", 32'(m_en), 32'(0));
        if (req == '0) post_random_new();
        expect_no_grant("no_grant_disabled", 25);
        enable = 1'b1;
        hold_busy = 1'b1;
        serve(model_pick(req, rr), 0, 1'b0, 1'b0);

        // Master still busy after the response: IDLE holds off.
        if (req == '0) post_random_new();
        expect_no_grant("no_grant_m_busy", 25);
        hold_busy = 1'b0;
        m_busy    = 1'b0;
        serve(model_pick(req, rr), 0, 1'b0, 1'b0);

        // Random traffic with random NACK patterns and immediate re-requests.
        for (int it = 0; it < 30; it++) begin
            int r;
            int nk;
            post_random_new();
            r  = int'($urandom_range(0, 9));
            nk = (r < 5) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
            serve(model_pick(req, rr), nk, ($urandom_range(0, 3) == 0), 1'b0);
        end

`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int waited = 0;
            int starts = 0;
            int tcyc = 0;
            if (req == '0) post_random_new();
            exp = model_pick(req, rr);
            do begin
                @(negedge clk);
                waited++;
            end while (!m_start && waited < 200);
            check("to_start_seen", 32'(m_start), 32'(1));
            check("to_gnt_idx", 32'(gnt_idx), 32'(exp));
            m_busy = 1'b1;
            do begin
                @(negedge clk);
                tcyc++;
                if (m_start) starts++;
            end while (rsp_valid == '0 && tcyc < 400);
            check("to_latency", 32'(tcyc), 32'(TO + 1));
            check("to_rsp_valid", 32'(rsp_valid), 32'(1) << exp);
            check("to_rsp_err", 32'(rsp_err), 32'(1));
            check("to_no_retry", 32'(starts), 32'(0));
            req[exp] = 1'b0;
            rr = (exp + 1) % N;
            repeat (10) @(negedge clk);
            check("to_flag_sticky", 32'(timeout_flag), 32'(1));
            rst_n = 1'b0;
            #1;
            check("to_flag_cleared", 32'(timeout_flag), 32'(0));
            m_busy = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares a single i2c_fsm write master between N_REQ independent requesters.
- Each requester posts a one-byte write with a 7-bit address and 8-bit data.
- The block grants requesters round-robin, sequences the i2c_fsm start/done handshake, and retries on NACK up to MAX_RETRY times.
- Returns a per-requester completion pulse with an error status. Sits between on-chip clients (sensor poller, config loader) and i2c_fsm.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 7, target address width.
- DATA_W, 8, write data width.
- MAX_RETRY, 2, extra attempts after a NACK (0 = no retry).
- BACKOFF_CYC, 16, idle clk cycles between a NACK completion and the retry (>=1).
- TIMEOUT_CYC, 65535, watchdog limit in clk cycles; used only with I2C_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- enable  in  1  arbiter enable; when 0, no new grants are issued
- req  in  N_REQ  per-requester request level
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
- rsp_valid  out  N_REQ  one-cycle completion pulse to the granted requester
- rsp_err  out  1  valid with rsp_valid; 1 = final attempt NACKed (or timed out)
- gnt_idx  out  $clog2(N_REQ)  index of the current/last granted requester
- arb_busy  out  1  1 in any state other than IDLE
- m_en  out  1  to i2c_fsm i2c_en; equals enable
- m_start  out  1  to i2c_fsm start, one-cycle pulse
- m_addr7  out  ADDR_W  to i2c_fsm addr7, latched
- m_tx_data  out  DATA_W  to i2c_fsm tx_data, latched
- m_tx_data_valid  out  1  to i2c_fsm tx_data_valid, asserted together with m_start
- m_busy  in  1  from i2c_fsm busy
- m_done  in  1  from i2c_fsm done, one-cycle pulse
- m_ack_error  in  1  from i2c_fsm ack_error, level while the master is in its error state

Behaviour:
- Reset: all outputs 0 (including gnt_idx=0); state IDLE; rr_ptr=0; retry_cnt=0; err_seen=0.
- States: IDLE, ISSUE, WAIT_DONE, BACKOFF, RESP.
- IDLE → ISSUE when enable && |req && !m_busy.
  - Winner: first i with req[i]=1, searching circularly from rr_ptr.
  - Latch m_addr7 and m_tx_data from the winner's slice; set gnt_idx; retry_cnt=0; err_seen=0.
- ISSUE:
  - m_start=1 and m_tx_data_valid=1 for exactly one cycle.
  - Clear err_seen and the watchdog counter.
  - Always → WAIT_DONE.
- WAIT_DONE:
  - err_seen |= m_ack_error each cycle.
  - On m_done, compute e = err_seen | m_ack_error:
    - e && retry_cnt < MAX_RETRY → BACKOFF, retry_cnt++.
    - Otherwise → RESP with rsp_err = e.
- BACKOFF:
  - Count BACKOFF_CYC cycles, then → ISSUE with the same latched addr/data.
  - A retry is not blocked by enable=0.
- RESP:
  - rsp_valid[gnt_idx]=1 for one cycle with rsp_err.
  - rr_ptr = gnt_idx+1, wrapping to 0 at N_REQ.
  - → IDLE.
- Requester contract:
  - Hold req, addr and data stable from assertion until its rsp_valid.
  - req still high in the cycle after rsp_valid is a new request.
  - Dropping req before rsp_valid is illegal; the transaction still completes and the response is still pulsed.
- Fairness: a requester re-asserting immediately is not granted again while another req bit is set.
- Minimum latency, IDLE grant to m_start: 1 cycle.
- Response latency: rsp_valid follows m_done by 1 cycle.
- enable falling mid-transaction: the current transaction, including retries, completes normally.
- Simultaneous m_done and m_ack_error in the same cycle: counts as error.
- rsp_err is 0 whenever no rsp_valid bit is set.
- Reset asserted mid-operation: immediate return to reset values; no response is issued for the aborted request.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT_DONE.
  - Reaching TIMEOUT_CYC without m_done → RESP with rsp_err=1, no retry.
  - Sets sticky output timeout_flag (1 bit, extra port), cleared only by reset.
  - IDLE still waits for !m_busy before the next grant.
- Not defined: no counter and no timeout_flag port; WAIT_DONE waits indefinitely.

Decomposition:
- Package i2c_arb_pkg: arb_state_t enum, default parameter constants, and a function rr_pick(req, ptr) returning the circular first-set index.
- One sub-module: i2c_rr_picker (combinational round-robin priority picker, N_REQ wide); the FSM and datapath stay in the top.

Test Plan:
- Single request: req[1]=1, addr=0x50, data=0xA5, slave ACKs → one m_start with m_addr7=0x50, m_tx_data=0xA5; rsp_valid[1] one cycle after m_done; rsp_err=0.
- Round-robin: req=4'b1111 held continuously → grant order 0,1,2,3,0; no requester granted twice before the others.
- NACK with retry, MAX_RETRY=2: address NACKed twice, then ACKed → 3 m_start pulses, each retry separated by ≥16 idle cycles; rsp_err=0.
- Persistent NACK → exactly 3 attempts, then rsp_valid with rsp_err=1; rr_ptr advances.
- enable dropped during WAIT_DONE → transaction completes and is responded; new req stays ungranted until enable=1. Same test with m_busy held high: no grant until it falls.
- I2C_ARB_TIMEOUT_EN, TIMEOUT_CYC=100, m_done never arrives → rsp_err=1 at cycle 100; timeout_flag=1 until rst_n; no retry issued.
